// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetcher with direct-mapped instruction cache
//
// Fetches one 32-bit instruction at a time from pc, using a direct-mapped
// cache of ICACHE_LINES one-word lines, and presents it to the decoder until
// the decoder accepts it. The next pc comes from the decoder (predict_pc) or
// from a misprediction flush (clear_pc).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable; all state holds while low
//   rob_full/rs_full/lsb_full  downstream capacity flags (accept condition)
//   instr_issued, predict_pc decoder issued the instruction; next pc
//   clear, clear_pc          flush request and corrected pc
//   mem_done, mem_data       memory read completion and returned word
//   mem_req, mem_addr        memory read request and its address
//   instr_ready, instr_out, instr_addr_out  instruction presented to decoder

module fetcher #(
  parameter int ICACHE_LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  input  logic        instr_issued,
  input  logic [31:0] predict_pc,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [2:0] {
    FETCH,
    MISS,
    PRESENT,
    WAIT_PC,
    DISCARD
  } state_t;

  state_t                  state;
  logic [31:0]             pc;
  logic [31:0]             line_data [ICACHE_LINES];
  logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] line_valid;

  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             hit;
  logic             accept;

  assign pc_idx = pc[IDX_W+1:2];
  assign pc_tag = pc[31:IDX_W+2];
  assign hit    = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
  // Must match the decoder's own issue condition so both sides agree on
  // which edge the instruction was taken.
  assign accept = !rob_full && !rs_full && !lsb_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= 32'h0;
      line_valid     <= '0;
      instr_ready    <= 1'b0;
      mem_req        <= 1'b0;
      mem_addr       <= 32'h0;
      instr_out      <= 32'h0;
      instr_addr_out <= 32'h0;
    end else if (rdy) begin
      if (clear) begin
        pc          <= clear_pc;
        instr_ready <= 1'b0;
        mem_req     <= 1'b0;
        // A read still outstanding must be drained before a new one starts;
        // a read completing on this very edge is simply dropped.
        if ((state == MISS || state == DISCARD) && !mem_done)
          state <= DISCARD;
        else
          state <= FETCH;
      end else begin
        case (state)
          FETCH: begin
            if (hit) begin
              instr_out      <= line_data[pc_idx];
              instr_addr_out <= pc;
              instr_ready    <= 1'b1;
              state          <= PRESENT;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= pc;
              state    <= MISS;
            end
          end
          MISS: begin
            if (mem_done) begin
              line_data[pc_idx]  <= mem_data;
              line_tag[pc_idx]   <= pc_tag;
              line_valid[pc_idx] <= 1'b1;
              mem_req            <= 1'b0;
              instr_out          <= mem_data;
              instr_addr_out     <= pc;
              instr_ready        <= 1'b1;
              state              <= PRESENT;
            end
          end
          PRESENT: begin
            if (accept) begin
              instr_ready <= 1'b0;
              state       <= WAIT_PC;
            end
          end
          WAIT_PC: begin
            if (instr_issued) begin
              pc    <= predict_pc;
              state <= FETCH;
            end
          end
          DISCARD: begin
            if (mem_done)
              state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 ICACHE_LINES, 16, number of direct-mapped instruction-cache lines (power of two, one 32-bit word per line).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; when low, all state holds.
REQ-005 rob_full / rs_full / lsb_full  input  1 each  downstream capacity flags, also consumed by the decoder.
REQ-006 instr_issued  input  1  decoder issued the presented instruction last edge; predict_pc valid this cycle.
REQ-007 predict_pc  input  32  next PC chosen by the decoder.
REQ-008 clear  input  1  misprediction flush from RoB.
REQ-009 clear_pc  input  32  corrected PC, valid with clear.
REQ-010 mem_done  input  1  one-cycle pulse: mem_data valid.
REQ-011 mem_data  input  32  fetched instruction word.
REQ-012 mem_req  output  1  instruction-read request, held high until mem_done.
REQ-013 mem_addr  output  32  word address of the request.
REQ-014 instr_ready  output  1  instr_out/instr_addr_out valid for the decoder.
REQ-015 instr_out  output  32  instruction word.
REQ-016 instr_addr_out  output  32  PC of instr_out.

Function
REQ-017 States: FETCH, MISS, PRESENT, WAIT_PC, DISCARD; all outputs registered.
REQ-018 Cache: index pc[log2(ICACHE_LINES)+1:2], tag = remaining upper pc bits, one valid bit per line.
REQ-019 FETCH, hit: instr_out <= line data, instr_addr_out <= pc, instr_ready <= 1, next state PRESENT (one-cycle hit latency).
REQ-020 FETCH, miss: mem_req <= 1, mem_addr <= pc, next state MISS.
REQ-021 MISS: on mem_done, write the line (data, tag, valid <= 1), mem_req <= 0, present mem_data as in REQ-019, next state PRESENT.
REQ-022 PRESENT: accept = !rob_full && !rs_full && !lsb_full (the same condition the decoder evaluates); on accept, instr_ready <= 0 at that edge, next state WAIT_PC; otherwise hold with outputs stable.
REQ-023 instr_ready is high for exactly the cycles in PRESENT, so each instruction is issued exactly once.
REQ-024 WAIT_PC: when instr_issued = 1, pc <= predict_pc, next state FETCH; otherwise remain.
REQ-025 clear has priority over all other events in every state: pc <= clear_pc, instr_ready <= 0, mem_req <= 0.
REQ-026 clear in MISS before mem_done: next state DISCARD; otherwise next state FETCH.
REQ-027 clear coincident with mem_done in MISS: data dropped, no cache write, next state FETCH.
REQ-028 DISCARD: wait for mem_done, drop data, no cache write, next state FETCH; a further clear updates pc and stays in DISCARD.
REQ-029 instr_issued arriving after a clear (wrong-path issue) is ignored; predict_pc is not loaded.
REQ-030 The cache is never invalidated by clear.
REQ-031 rdy low: no state, pc, cache or output changes; a mem_done pulse during rdy low is not required to be captured (mem controller shares rdy).

Reset
REQ-032 On rst: pc = 0, state FETCH, all valid bits 0, instr_ready = 0, mem_req = 0, mem_addr = 0, instr_out = 0, instr_addr_out = 0.
REQ-033 rst mid-MISS abandons the request; no cache write from an in-flight return.

Verification
REQ-034 Reset, mem returns 0x00500093 at 0 after 3 cycles, decoder not full -> mem_req held 3 cycles with mem_addr = 0; instr_ready 1 cycle with instr_out = 0x00500093, instr_addr_out = 0.
REQ-035 predict_pc = 0x0 on instr_issued (loop) -> second fetch hits, no mem_req, instr_ready one cycle after FETCH entry.
REQ-036 rob_full = 1 for 5 cycles while PRESENT -> instr_ready and instr_out stable 5 cycles, drop the edge after rob_full falls.
REQ-037 clear with clear_pc = 0x100 during MISS at 0x40, mem_done 2 cycles later -> DISCARD, line 0x40 not filled, then mem_req with mem_addr = 0x100.
REQ-038 clear in WAIT_PC, instr_issued with predict_pc = 0x8 next cycle -> pc = clear_pc, 0x8 never fetched.
REQ-039 Addresses 0x04 and 0x44 (same index, ICACHE_LINES = 16) alternated -> every access misses, correct data each time.
